// File: rtl/dmem_responder.sv
// Data-memory responder: 32 x 32-bit words behind a valid/ready request
// channel, with a programmable wait before a response held until accepted.
module dmem_responder #(
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_we,
   output logic [31:0] rsp_rdata,
   output logic        busy,
   output logic [15:0] acc_count
);

   generate
      if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_rlat
         $error("dmem_responder: READ_LAT must be 1..15");
      end
      if (WRITE_LAT < 1 || WRITE_LAT > 15) begin : g_bad_wlat
         $error("dmem_responder: WRITE_LAT must be 1..15");
      end
   endgenerate

   localparam logic [3:0] RL = 4'(READ_LAT);
   localparam logic [3:0] WL = 4'(WRITE_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [4:0]  addr_q, addr_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_we_q, rsp_we_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [15:0] acc_q, acc_d;
   logic [31:0] mem_q [32];

   logic       accept;
   logic [3:0] lat;

   assign accept = req_valid && (state_q == IDLE);
   assign lat    = req_we ? WL : RL;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 5'd0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= 32'd0;
         acc_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
         acc_q       <= acc_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (accept && req_we) begin
         mem_q[req_addr] <= req_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (lat == 4'd1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = lat - 4'd2;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A LAT=1 read enters RESP on its accept edge, so read via the _d capture.
   always_comb begin
      we_d        = we_q;
      addr_d      = addr_q;
      acc_d       = acc_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_rdata_d = rsp_rdata_q;
      if (accept) begin
         we_d   = req_we;
         addr_d = req_addr;
         acc_d  = acc_q + 16'd1;
      end
      if (state_q != RESP && state_d == RESP) begin
         rsp_valid_d = 1'b1;
         rsp_we_d    = we_d;
         rsp_rdata_d = we_d ? 32'd0 : mem_q[addr_d];
      end
      if (state_q == RESP && rsp_ready) begin
         rsp_valid_d = 1'b0;
         rsp_rdata_d = 32'd0;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_rdata = rsp_rdata_q;
   assign acc_count = acc_q;

endmodule
